// File: rtl/issue_sequencer_pkg.sv
// Shared widths, the all-ones delay sentinel, FSM state encoding and opcode constants
// for the issue sequencer (optional watchdog: ISSUE_TIMEOUT_EN).
package issue_sequencer_pkg;

    localparam int OPR_W = 5;
    localparam int DLY_W = 8;

    // A delay select of all-ones means "wait for alu_done, no fixed count".
    localparam logic [DLY_W-1:0] DLY_INF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [OPR_W-1:0] OPR_MOV  = 5'd0;
    localparam logic [OPR_W-1:0] OPR_ADD  = 5'd1;
    localparam logic [OPR_W-1:0] OPR_SUB  = 5'd2;
    localparam logic [OPR_W-1:0] OPR_MUL  = 5'd3;
    localparam logic [OPR_W-1:0] OPR_AND  = 5'd4;
    localparam logic [OPR_W-1:0] OPR_OR   = 5'd5;
    localparam logic [OPR_W-1:0] OPR_PRNG = 5'd6;
    localparam logic [OPR_W-1:0] OPR_XOR  = 5'd7;
    localparam logic [OPR_W-1:0] OPR_SHL  = 5'd8;
    localparam logic [OPR_W-1:0] OPR_SHR  = 5'd9;
    localparam logic [OPR_W-1:0] OPR_CMP  = 5'd10;
    localparam logic [OPR_W-1:0] OPR_JMP  = 5'd11;
    localparam logic [OPR_W-1:0] OPR_JRE  = 5'd12;

endpackage

// File: rtl/issue_dly_cnt.sv
// Loadable down-counter that saturates at zero; loading the all-ones value sets an
// infinite-hold flag that freezes the count. Zero and infinite flags are exported.
module issue_dly_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         inf
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         inf_q, inf_d;

    always_comb begin
        cnt_d = cnt_q;
        inf_d = inf_q;
        if (load) begin
            cnt_d = load_val;
            inf_d = &load_val;
        end else if (dec && !inf_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            inf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inf_q <= inf_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign inf  = inf_q;

endmodule

// File: rtl/issue_sequencer.sv
// Issues one decoded instruction at a time: start strobe, timed or done-terminated wait,
// one-cycle writeback, fetch stalled throughout. ISSUE_TIMEOUT_EN adds a WAIT watchdog.
module issue_sequencer #(
    parameter int OPR_W = issue_sequencer_pkg::OPR_W,
    parameter int DLY_W = issue_sequencer_pkg::DLY_W
`ifdef ISSUE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_vld,
    output logic             instr_rdy,
    input  logic [OPR_W-1:0] opr_typ,
    input  logic             dly_sel,
    input  logic [DLY_W-1:0] dly,
    input  logic             alu_sel,
    input  logic             prng_sel,
    input  logic             alu_done,
    output logic             alu_start,
    output logic             prng_start,
    output logic             wb_en,
    output logic [OPR_W-1:0] opr_cur,
    output logic             pc_stall,
    output logic             err
);

    import issue_sequencer_pkg::*;

    state_t           state_q, state_d;
    logic [OPR_W-1:0] opr_q, opr_d;
    logic             alu_sel_q, alu_sel_d;
    logic             instr_rdy_q, pc_stall_q, wb_en_q;
    logic             alu_start_q, alu_start_d;
    logic             prng_start_q, prng_start_d;
    logic             cnt_load, cnt_dec, cnt_zero, cnt_inf;
    logic             transfer, done_hit, fixed_exit;
    logic             wd_hit, wd_abort;

    issue_dly_cnt #(.W(DLY_W)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (dly),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .inf      (cnt_inf)
    );

    assign transfer   = instr_vld && instr_rdy_q;
    assign done_hit   = alu_sel_q && alu_done;
    assign fixed_exit = cnt_zero && !cnt_inf;

    // The counter also steps during ISSUE so that a delay of N gives N WAIT cycles.
    always_comb begin
        state_d      = state_q;
        opr_d        = opr_q;
        alu_sel_d    = alu_sel_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        alu_start_d  = 1'b0;
        prng_start_d = 1'b0;
        wd_abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (transfer && dly_sel) begin
                    state_d      = ST_ISSUE;
                    opr_d        = opr_typ;
                    alu_sel_d    = alu_sel;
                    cnt_load     = 1'b1;
                    alu_start_d  = alu_sel;
                    prng_start_d = prng_sel;
                end
            end
            ST_ISSUE: begin
                cnt_dec = 1'b1;
                state_d = (done_hit || fixed_exit) ? ST_WB : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (done_hit || fixed_exit) begin
                    state_d = ST_WB;
                end else if (wd_hit) begin
                    state_d  = ST_WB;
                    wd_abort = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opr_q        <= '0;
            alu_sel_q    <= 1'b0;
            instr_rdy_q  <= 1'b1;
            pc_stall_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            alu_start_q  <= 1'b0;
            prng_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opr_q        <= opr_d;
            alu_sel_q    <= alu_sel_d;
            instr_rdy_q  <= (state_d == ST_IDLE);
            pc_stall_q   <= (state_d != ST_IDLE);
            wb_en_q      <= (state_d == ST_WB) && !wd_abort;
            alu_start_q  <= alu_start_d;
            prng_start_q <= prng_start_d;
        end
    end

`ifdef ISSUE_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE) begin
                wd_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wd_hit = (state_q == ST_WAIT) && (wd_q == WD_LAST);
    assign err    = err_q;
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    assign instr_rdy  = instr_rdy_q;
    assign pc_stall   = pc_stall_q;
    assign wb_en      = wb_en_q;
    assign alu_start  = alu_start_q;
    assign prng_start = prng_start_q;
    assign opr_cur    = opr_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// Randomized bench for issue_sequencer; expected strobe cycles come from the timing rules
// (start at T+1, wb at T+dly+2 or done+1, watchdog cut-off) relative to each transfer.
module tb_issue_sequencer;

    import issue_sequencer_pkg::*;

    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_vld;
    logic       instr_rdy;
    logic [4:0] opr_typ;
    logic       dly_sel;
    logic [7:0] dly;
    logic       alu_sel;
    logic       prng_sel;
    logic       alu_done;
    logic       alu_start;
    logic       prng_start;
    logic       wb_en;
    logic [4:0] opr_cur;
    logic       pc_stall;
    logic       err;

    int         n_chk = 0;
    int         n_err = 0;
    logic [4:0] cur_opr = '0;
    logic       err_exp = 1'b0;

    always #5 clk = ~clk;

`ifdef ISSUE_TIMEOUT_EN
    issue_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
`else
    issue_sequencer dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .instr_vld  (instr_vld),
        .instr_rdy  (instr_rdy),
        .opr_typ    (opr_typ),
        .dly_sel    (dly_sel),
        .dly        (dly),
        .alu_sel    (alu_sel),
        .prng_sel   (prng_sel),
        .alu_done   (alu_done),
        .alu_start  (alu_start),
        .prng_start (prng_start),
        .wb_en      (wb_en),
        .opr_cur    (opr_cur),
        .pc_stall   (pc_stall),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdy"},   32'(instr_rdy),  32'd1);
        chk({tag, "_stall"}, 32'(pc_stall),   32'd0);
        chk({tag, "_wb"},    32'(wb_en),      32'd0);
        chk({tag, "_astart"},32'(alu_start),  32'd0);
        chk({tag, "_pstart"},32'(prng_start), 32'd0);
        chk({tag, "_opr"},   32'(opr_cur),    32'(cur_opr));
        chk({tag, "_err"},   32'(err),        32'(err_exp));
    endtask

    // Writeback cycle relative to the transfer cycle (0): fixed delay, early done, watchdog.
    function automatic int model_wb(input logic [7:0] d, input logic asel, input int done_off,
                                    output bit tmo);
        int wb;
        tmo = 1'b0;
        wb  = (d == DLY_INF) ? 1000000 : int'(d) + 2;
        if (asel && done_off >= 1 && done_off + 1 < wb) wb = done_off + 1;
`ifdef ISSUE_TIMEOUT_EN
        if (wb > TO_CYC + 2) begin
            wb  = TO_CYC + 2;
            tmo = 1'b1;
        end
`endif
        return wb;
    endfunction

    task automatic run_instr(input logic [4:0] opr, input logic dsel, input logic [7:0] d,
                             input logic asel, input logic psel, input int done_off);
        int  wb;
        int  n;
        int  c;
        bit  tmo;
        bit  busy;
        wb = 0;
        tmo = 1'b0;
        if (dsel) wb = model_wb(d, asel, done_off, tmo);
        n = dsel ? wb + 1 : 3;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                instr_vld = 1'b1;
                opr_typ   = opr;
                dly_sel   = dsel;
                dly       = d;
                alu_sel   = asel;
                prng_sel  = psel;
            end else begin
                // While busy the inputs carry junk that must not be accepted.
                instr_vld = (k <= wb) ? 1'($urandom) : 1'b0;
                opr_typ   = 5'($urandom);
                dly_sel   = 1'($urandom);
                dly       = 8'($urandom);
                alu_sel   = 1'($urandom);
                prng_sel  = 1'($urandom);
            end
            alu_done = (k == done_off);
            @(posedge clk);
            #1;
            c    = k + 1;
            busy = dsel && (c <= wb);
            if (dsel) cur_opr = opr;
            if (tmo && c == wb) err_exp = 1'b1;
            chk("alu_start",  32'(alu_start),  32'(dsel && asel && c == 1));
            chk("prng_start", 32'(prng_start), 32'(dsel && psel && c == 1));
            chk("wb_en",      32'(wb_en),      32'(dsel && !tmo && c == wb));
            chk("pc_stall",   32'(pc_stall),   32'(busy));
            chk("instr_rdy",  32'(instr_rdy),  32'(!busy));
            chk("opr_cur",    32'(opr_cur),    32'(cur_opr));
            chk("err",        32'(err),        32'(err_exp));
        end
        instr_vld = 1'b0;
        alu_done  = 1'b0;
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        instr_vld = 1'b1;
        opr_typ   = OPR_MUL;
        dly_sel   = 1'b1;
        dly       = DLY_INF;
        alu_sel   = 1'b1;
        prng_sel  = 1'b0;
        alu_done  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            instr_vld = 1'b0;
            @(posedge clk);
            #1;
            chk("rstmid_stall", 32'(pc_stall), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cur_opr = '0;
        err_exp = 1'b0;
        chk_quiet("rstmid_post");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk_quiet("rstmid_after");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] r_opr;
        logic [7:0] r_dly;
        logic       r_asel;
        logic       r_psel;
        logic       r_dsel;
        int         r_done;
        int         sel;

        rst       = 1'b1;
        instr_vld = 1'b0;
        opr_typ   = '0;
        dly_sel   = 1'b0;
        dly       = '0;
        alu_sel   = 1'b0;
        prng_sel  = 1'b0;
        alu_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst = 1'b0;

        run_instr(OPR_ADD,  1'b1, 8'd4,  1'b1, 1'b0, -1);
        run_instr(OPR_MUL,  1'b1, DLY_INF, 1'b1, 1'b0, 40);
        run_instr(OPR_PRNG, 1'b1, 8'd3,  1'b0, 1'b1, -1);
        run_instr(OPR_MOV,  1'b0, 8'd7,  1'b1, 1'b0, 1);
        run_instr(OPR_SUB,  1'b1, 8'd0,  1'b1, 1'b0, -1);
        run_instr(OPR_AND,  1'b1, 8'd10, 1'b1, 1'b0, 1);
        run_instr(OPR_OR,   1'b1, 8'd5,  1'b0, 1'b0, 2);
        run_instr(OPR_XOR,  1'b1, 8'd6,  1'b1, 1'b0, 0);
        run_instr(OPR_CMP,  1'b1, 8'd1,  1'b1, 1'b0, -1);
        reset_mid_wait();
`ifdef ISSUE_TIMEOUT_EN
        run_instr(OPR_MUL,  1'b1, DLY_INF, 1'b1, 1'b0, -1);
`endif

        for (int i = 0; i < 60; i++) begin
            r_opr  = 5'($urandom_range(0, 12));
            r_psel = (r_opr == OPR_PRNG);
            r_asel = r_psel ? 1'b0 : 1'($urandom);
            r_dsel = ($urandom_range(0, 7) != 0);
            sel    = $urandom_range(0, 9);
            if (sel < 4)       r_dly = 8'($urandom_range(0, 5));
            else if (sel < 8)  r_dly = 8'($urandom_range(6, 40));
            else if (sel == 8) r_dly = 8'($urandom_range(200, 254));
            else               r_dly = DLY_INF;
            if (r_dly == DLY_INF) begin
                r_asel = 1'b1;
                r_psel = 1'b0;
                r_done = $urandom_range(1, 60);
            end else if ($urandom_range(0, 1) == 0) begin
                r_done = -1;
            end else begin
                r_done = $urandom_range(0, int'(r_dly) + 3);
            end
            run_instr(r_opr, r_dsel, r_dly, r_asel, r_psel, r_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
